// File: rtl/nn_fifo_pkg.sv
// Shared helpers for the nn_stream_fifo slice: width derivation and
// parameter legality checks used at elaboration time.
package nn_fifo_pkg;

    // Pointer width: one bit per halving of DEPTH, never below one bit.
    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count width: one extra bit so a completely full FIFO is representable.
    function automatic int cntWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // True when value is a power of two and at least 2.
    function automatic bit isPow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

    // True when the almost-full threshold lies in 1..depth.
    function automatic bit afullLvlOk(input int lvl, input int depth);
        return (lvl >= 1) && (lvl <= depth);
    endfunction

endpackage

// File: rtl/nn_fifo_mem.sv
// Register-array storage for nn_stream_fifo: one synchronous write port and
// one asynchronous read port, kept separate so an SRAM macro can replace it.
module nn_fifo_mem
    import nn_fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = ptrWidth(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] memArray [DEPTH];

    // Write the addressed entry on the clock edge; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            memArray[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = memArray[raddr_i];

endmodule

// File: rtl/nn_stream_fifo.sv
// First-word-fall-through stream FIFO between the Wishbone slave and the NN
// compute core. Pointers, occupancy count and sticky error flags live here;
// the storage array lives in nn_fifo_mem.
module nn_stream_fifo
    import nn_fifo_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 push,
    input  logic [DATA_W-1:0]    data_i,
    input  logic                 pop,
    output logic [DATA_W-1:0]    data_o,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full,
    output logic [$clog2(DEPTH):0] count,
    output logic                 ovf,
    output logic                 udf
);

    localparam int PTR_W = ptrWidth(DEPTH);
    localparam int CNT_W = cntWidth(DEPTH);

    if (!isPow2(DEPTH)) begin : gDepthCheck
        $error("nn_stream_fifo: DEPTH must be a power of two and at least 2");
    end

    if (!afullLvlOk(AFULL_LVL, DEPTH)) begin : gAfullCheck
        $error("nn_stream_fifo: AFULL_LVL must lie in 1..DEPTH");
    end

    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              pushOk;
    logic              popOk;
    logic              memWe;
    logic [DATA_W-1:0] memRdata;

    // Status decodes of the registered count, valid alongside it.
    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign almost_full = (count_q >= CNT_W'(AFULL_LVL));

    // A pop frees a slot, so a push into a full FIFO is still taken when
    // paired with a pop; a pop into an empty FIFO is never taken.
    assign pushOk = push & (~full | pop);
    assign popOk  = pop & ~empty;

    // A flush drops the push of that cycle, including its storage write.
    assign memWe = pushOk & ~clr;

    nn_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) uMem (
        .clk_i   (clk),
        .we_i    (memWe),
        .waddr_i (wrPtr_q),
        .wdata_i (data_i),
        .raddr_i (rdPtr_q),
        .rdata_o (memRdata)
    );

    assign data_o = empty ? '0 : memRdata;
    assign count  = count_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;

    // Next-state for pointers, occupancy and sticky flags; flush wins over all.
    always_comb begin
        wrPtr_d = wrPtr_q + PTR_W'(pushOk);
        rdPtr_d = rdPtr_q + PTR_W'(popOk);
        ovf_d   = ovf_q | (push & ~pushOk);
        udf_d   = udf_q | (pop & empty);
        count_d = count_q;
        case ({pushOk, popOk})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (clr) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end
    end

    // Control state registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

endmodule

// File: tb/tb_nn_stream_fifo.sv
// Directed and random checks of nn_stream_fifo (DEPTH=8, AFULL_LVL=6) against
// a queue-based scoreboard that models occupancy, order and sticky flags.
module tb_nn_stream_fifo;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 8;
    localparam int AFULL_LVL = 6;

    logic              clk;
    logic              rst;
    logic              clr;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [3:0]        count;
    logic              ovf;
    logic              udf;

    int compared;
    int mismatched;
    int acceptedPushes;

    logic [DATA_W-1:0] modelQ [$];
    bit                modelOvf;
    bit                modelUdf;

    nn_stream_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .push        (push),
        .data_i      (data_i),
        .pop         (pop),
        .data_o      (data_o),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .ovf         (ovf),
        .udf         (udf)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and on disagreement counts and reports it.
    task automatic checkVal(input string tag, input logic [DATA_W-1:0] observed,
                            input logic [DATA_W-1:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Compare every DUT output with the scoreboard.
    task automatic checkOutput(input string tag);
        int n;
        n = modelQ.size();
        checkVal({tag, ".count"}, DATA_W'(count), DATA_W'(n));
        checkVal({tag, ".empty"}, DATA_W'(empty), DATA_W'(n == 0));
        checkVal({tag, ".full"}, DATA_W'(full), DATA_W'(n == DEPTH));
        checkVal({tag, ".almost_full"}, DATA_W'(almost_full), DATA_W'(n >= AFULL_LVL));
        checkVal({tag, ".ovf"}, DATA_W'(ovf), DATA_W'(modelOvf));
        checkVal({tag, ".udf"}, DATA_W'(udf), DATA_W'(modelUdf));
        checkVal({tag, ".data_o"}, data_o, (n != 0) ? modelQ[0] : '0);
    endtask

    // Clear the scoreboard as a reset or flush would.
    task automatic modelClear();
        modelQ.delete();
        modelOvf = 1'b0;
        modelUdf = 1'b0;
    endtask

    // Drive one cycle of inputs, check a consumed word, advance the model.
    task automatic applyStimulus(input string tag, input bit p, input bit q,
                                 input bit c, input logic [DATA_W-1:0] d);
        bit pOk;
        bit qOk;
        push   = p;
        pop    = q;
        clr    = c;
        data_i = d;
        if (!c && q && modelQ.size() != 0) begin
            checkVal({tag, ".popData"}, data_o, modelQ[0]);
        end
        @(posedge clk);
        #1;
        if (c) begin
            modelClear();
        end else begin
            pOk = p && ((modelQ.size() < DEPTH) || q);
            qOk = q && (modelQ.size() != 0);
            if (p && !pOk) modelOvf = 1'b1;
            if (q && modelQ.size() == 0) modelUdf = 1'b1;
            if (qOk) void'(modelQ.pop_front());
            if (pOk) begin
                modelQ.push_back(d);
                acceptedPushes++;
            end
        end
        push   = 1'b0;
        pop    = 1'b0;
        clr    = 1'b0;
        data_i = '0;
        checkOutput(tag);
    endtask

    // Directed sequence followed by random streaming and a mid-stream reset.
    initial begin
        compared       = 0;
        mismatched     = 0;
        acceptedPushes = 0;
        rst    = 1'b0;
        clr    = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        data_i = '0;
        modelClear();

        $display("[TB] reset and fill");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkVal("rstAsync.empty", DATA_W'(empty), DATA_W'(1));
        checkVal("rstAsync.data_o", data_o, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("afterReset");

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("fill", 1'b1, 1'b0, 1'b0, DATA_W'(32'h11 + i));
        end
        checkVal("fill.fullFlag", DATA_W'(full), DATA_W'(1));
        checkVal("fill.count8", DATA_W'(count), DATA_W'(8));

        $display("[TB] overflow");
        applyStimulus("ovfPush", 1'b1, 1'b0, 1'b0, 32'h99);
        checkVal("ovf.flag", DATA_W'(ovf), DATA_W'(1));
        for (int i = 0; i < DEPTH; i++) begin
            checkVal("drain.order", data_o, DATA_W'(32'h11 + i));
            applyStimulus("drain", 1'b0, 1'b1, 1'b0, '0);
        end
        checkVal("drain.empty", DATA_W'(empty), DATA_W'(1));

        $display("[TB] underflow and flush");
        applyStimulus("udfPop", 1'b0, 1'b1, 1'b0, '0);
        checkVal("udf.flag", DATA_W'(udf), DATA_W'(1));
        applyStimulus("clr", 1'b1, 1'b0, 1'b1, 32'h77);
        checkVal("clr.udf", DATA_W'(udf), DATA_W'(0));
        checkVal("clr.ovf", DATA_W'(ovf), DATA_W'(0));

        $display("[TB] simultaneous push and pop");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("refill", 1'b1, 1'b0, 1'b0, DATA_W'(32'h21 + i));
        end
        applyStimulus("fullPushPop", 1'b1, 1'b1, 1'b0, 32'hAA);
        checkVal("fullPushPop.count", DATA_W'(count), DATA_W'(8));
        checkVal("fullPushPop.head", data_o, 32'h22);
        for (int i = 0; i < DEPTH - 1; i++) begin
            applyStimulus("popToAA", 1'b0, 1'b1, 1'b0, '0);
        end
        checkVal("popToAA.head", data_o, 32'hAA);
        applyStimulus("popAA", 1'b0, 1'b1, 1'b0, '0);
        applyStimulus("emptyPushPop", 1'b1, 1'b1, 1'b0, 32'hBB);
        checkVal("emptyPushPop.count", DATA_W'(count), DATA_W'(1));
        checkVal("emptyPushPop.data", data_o, 32'hBB);
        checkVal("emptyPushPop.udf", DATA_W'(udf), DATA_W'(1));

        $display("[TB] random streaming");
        applyStimulus("clrRand", 1'b0, 1'b0, 1'b1, '0);
        acceptedPushes = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus("rand", $urandom_range(0, 15) != 0, $urandom_range(0, 15) != 0,
                          1'b0, DATA_W'($urandom));
        end
        checkVal("rand.wraps", DATA_W'((acceptedPushes / DEPTH) >= 10), DATA_W'(1));

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus("clrMid", 1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus("mid", 1'b1, 1'b0, 1'b0, DATA_W'(32'h40 + i));
        end
        checkVal("mid.count5", DATA_W'(count), DATA_W'(5));
        #2;
        rst = 1'b1;
        #1;
        modelClear();
        checkVal("midRst.count", DATA_W'(count), DATA_W'(0));
        checkVal("midRst.empty", DATA_W'(empty), DATA_W'(1));
        checkVal("midRst.almost_full", DATA_W'(almost_full), DATA_W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midRstRelease");
        applyStimulus("postRst", 1'b1, 1'b0, 1'b0, 32'hCC);
        checkVal("postRst.data", data_o, 32'hCC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/nn_stream_fifo.md
Name: nn_stream_fifo

Overview:
- Parametrised synchronous FIFO for the wishbone_nn datapath. Buffers input/activation words between the Wishbone slave and the NN compute core.
- Generalises the fixed 8x32 input FIFO in four ways:
  - configurable width, depth and almost-full threshold;
  - independent push/pop strobes, with simultaneous push+pop in one cycle;
  - first-word-fall-through read;
  - an occupancy count that can represent a completely full FIFO, plus sticky overflow/underflow error flags.

Parameters:
- DATA_W, 32: data word width in bits.
- DEPTH, 8: number of entries. Must be a power of two, >= 2.
- AFULL_LVL, DEPTH-2: almost_full asserts when count >= AFULL_LVL. Legal range is 1..DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush; same effect as reset except that it takes effect on the clock edge.
- push  in  1  write strobe.
- data_i  in  DATA_W  write data.
- pop  in  1  read-acknowledge strobe; consumes the word currently on data_o.
- data_o  out  DATA_W  head-of-queue word (FWFT).
- empty  out  1  high when count == 0.
- full  out  1  high when count == DEPTH.
- almost_full  out  1  high when count >= AFULL_LVL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- ovf  out  1  sticky: a push was attempted while full and not accepted.
- udf  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (rst high, asynchronous): wr_ptr=0, rd_ptr=0, count=0, ovf=0, udf=0.
  - Resulting outputs: empty=1, full=0, almost_full=0, data_o=0.
  - Storage array is not reset.
- clr (sampled at posedge while rst low): same state as reset. clr has priority over push/pop in that cycle, so the push is dropped and neither flag is set.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. There is no separate wrap logic.
- Accept rules, evaluated at posedge:
  - push_ok = push & (~full | pop)
  - pop_ok = pop & ~empty
- Push full+pop case: when full, a simultaneous push and pop are both accepted.
  - count stays at DEPTH.
  - The head advances.
  - The new word is written to the slot just freed (wr_ptr == rd_ptr when full).
- Push empty+pop case: when empty, a simultaneous push and pop are handled as follows.
  - The push is accepted.
  - The pop is ignored and udf is set.
  - count becomes 1.
- Effect of an accepted push: mem[wr_ptr] <= data_i; wr_ptr+1.
- Effect of an accepted pop: rd_ptr+1.
- count update:
  - +1 on push_ok only;
  - -1 on pop_ok only;
  - unchanged when both or neither are accepted.
- Error flags:
  - ovf <= ovf | (push & ~push_ok).
  - udf <= udf | (pop & empty).
  - Both are cleared only by rst or clr.
- Status flags (empty, full, almost_full) are combinational decodes of the registered count and are valid in the same cycle as count.
- data_o = empty ? 0 : mem[rd_ptr].
  - Combinational read, zero-latency FWFT.
  - A word pushed at edge N is visible on data_o after edge N when the FIFO was empty.
- Stored data is never modified by rejected pushes.
- Invariants:
  - count == (wr_ptr - rd_ptr) mod DEPTH, or count == DEPTH when the pointers are equal and the FIFO is full.
  - count never exceeds DEPTH and never underflows.

Decomposition:
- Package nn_fifo_pkg holds:
  - a constant-function wrapper for pointer/count widths (PTR_W, CNT_W derived from DEPTH);
  - an elaboration check that DEPTH is a power of two and that AFULL_LVL is in range.
- Sub-module nn_fifo_mem:
  - a DEPTH x DATA_W register array with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata);
  - isolates storage so it can later be swapped for an SRAM macro.
- Control logic (pointers, count, flags) stays in nn_stream_fifo.

Test Plan:
- Reset and fill:
  - Stimulus: assert rst mid-cycle; release; push 0x11..0x18 on 8 consecutive cycles (DEPTH=8, AFULL_LVL=6).
  - Required: during rst, empty=1 and data_o=0 immediately, without waiting for a clock edge. almost_full rises when count=6. full=1 and count=8 after the 8th push. ovf=0.
- Overflow:
  - Stimulus: while full, push 0x99 without pop.
  - Required: ovf=1 and count stays 8. Popping 8 times then returns 0x11..0x18 in order with no 0x99. empty=1 at the end.
- Underflow:
  - Stimulus: pop while empty.
  - Required: udf=1, count=0, data_o=0.
  - Stimulus: then clr.
  - Required: udf=0, ovf=0.
- Simultaneous push+pop:
  - Stimulus: while full, push 0xAA with pop.
  - Required: count=8, head advances. After 7 further pops, data_o=0xAA.
  - Stimulus: while empty, push 0xBB with pop.
  - Required: count=1, data_o=0xBB, udf=1.
- Wrap-around streaming:
  - Stimulus: 100 cycles of random push/pop against a scoreboard model.
  - Required: output order matches the model exactly, count matches the model every cycle, and the pointers wrap at least 10 times.
- Asynchronous reset mid-stream:
  - Stimulus: with count=5, assert rst between clock edges.
  - Required: count=0, empty=1 and almost_full=0 without waiting for a clock edge. The next push after release appears on data_o.
